// File: rtl/cu_pkg.sv
// Shared control-unit definitions: opcodes, car_ctrl encodings
// and microroutine base addresses used by sequencer and ucode ROM.
package cu_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    DISP = 2'b01,
    INC  = 2'b10,
    RET  = 2'b11
  } car_ctrl_e;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JGZ    = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  localparam logic [6:0] A_IF      = 7'h00;
  localparam logic [6:0] A_FO      = 7'h04;
  localparam logic [6:0] A_IND1    = 7'h05;
  localparam logic [6:0] A_STORE   = 7'h07;
  localparam logic [6:0] A_STORE_R = 7'h08;
  localparam logic [6:0] A_LOAD    = 7'h09;
  localparam logic [6:0] A_ADD     = 7'h0B;
  localparam logic [6:0] A_SUB     = 7'h0D;
  localparam logic [6:0] A_MPY     = 7'h0F;
  localparam logic [6:0] A_JMP     = 7'h11;
  localparam logic [6:0] A_HALT    = 7'h13;
  localparam logic [6:0] A_AND     = 7'h15;
  localparam logic [6:0] A_OR      = 7'h17;
  localparam logic [6:0] A_NOT     = 7'h19;
  localparam logic [6:0] A_SHR     = 7'h1B;
  localparam logic [6:0] A_SHL     = 7'h1D;
  localparam logic [6:0] A_NOP     = 7'h1F;
  localparam logic [6:0] A_STOREH  = 7'h21;
  localparam logic [6:0] A_MAX     = 7'h7F;

  localparam logic [15:0] RET_MAX  = 16'hFFFF;

endpackage

// File: rtl/car_dispatch.sv
// Opcode/flag dispatch: opcode, acc_gt0 -> target car, illegal.
// Unmapped opcodes land on the NOP routine with illegal set.
module car_dispatch
  import cu_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       acc_gt0,
  output logic [6:0] target,
  output logic       illegal
);

  always_comb begin
    target  = A_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_STORE: target = A_STORE;
      OP_LOAD:  target = A_LOAD;
      OP_ADD:   target = A_ADD;
      OP_SUB:   target = A_SUB;
      OP_JGZ:   target = acc_gt0 ? A_JMP : A_NOP;
      OP_JMP:   target = A_JMP;
      OP_HALT:  target = A_HALT;
      OP_MPY:   target = A_MPY;
      OP_AND:   target = A_AND;
      OP_OR:    target = A_OR;
      OP_NOT:   target = A_NOT;
      OP_SHR:   target = A_SHR;
      OP_SHL:   target = A_SHL;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/car_sequencer.sv
// Microprogram sequencer: clk, rst, control-word fields and flags
// in; car, halted, instr_done, retired, err registered out.
module car_sequencer
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_bit,
  input  logic [1:0]  car_ctrl,
  input  logic [7:0]  opcode,
  input  logic        ind,
  input  logic        acc_gt0,
  input  logic        mf,
  input  logic        start,
  output logic [6:0]  car,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] retired,
  output logic        err
);

  logic [6:0]  tgt;
  logic        ill;
  logic [6:0]  car_nxt;
  logic        halted_nxt;
  logic        done_nxt;
  logic        err_nxt;
  logic [15:0] ret_nxt;

  car_dispatch u_disp (
    .opcode  (opcode),
    .acc_gt0 (acc_gt0),
    .target  (tgt),
    .illegal (ill)
  );

  always_comb begin
    car_nxt    = car;
    halted_nxt = halted;
    done_nxt   = 1'b0;
    err_nxt    = err;
    ret_nxt    = retired;
    if (halted) begin
      // a simultaneous halt request wins over start
      if (start && !halt_bit) begin
        halted_nxt = 1'b0;
        car_nxt    = A_IF;
      end
    end else begin
      unique case (car_ctrl_e'(car_ctrl))
        HOLD: car_nxt = car;
        INC: begin
          car_nxt = car + 7'd1;
          if (car == A_MAX) err_nxt = 1'b1;
        end
        DISP: begin
          if (car == A_FO && ind) begin
            car_nxt = A_IND1;
          end else begin
            car_nxt = tgt;
            if (ill) err_nxt = 1'b1;
          end
        end
        RET: begin
          if (car == A_STORE_R && mf) begin
            car_nxt = A_STOREH;
          end else begin
            car_nxt  = A_IF;
            done_nxt = 1'b1;
            if (retired != RET_MAX)
              ret_nxt = retired + 16'd1;
          end
        end
      endcase
      if (halt_bit) halted_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      car        <= A_IF;
      halted     <= 1'b0;
      instr_done <= 1'b0;
      retired    <= 16'd0;
      err        <= 1'b0;
    end else begin
      car        <= car_nxt;
      halted     <= halted_nxt;
      instr_done <= done_nxt;
      retired    <= ret_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_car_sequencer.sv
// Self-checking bench for car_sequencer: directed routines plus
// random instruction streams against a behavioural model.
module tb_car_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt_bit;
  logic [1:0]  car_ctrl;
  logic [7:0]  opcode;
  logic        ind;
  logic        acc_gt0;
  logic        mf;
  logic        start;
  logic [6:0]  car;
  logic        halted;
  logic        instr_done;
  logic [15:0] retired;
  logic        err;

  car_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .halt_bit   (halt_bit),
    .car_ctrl   (car_ctrl),
    .opcode     (opcode),
    .ind        (ind),
    .acc_gt0    (acc_gt0),
    .mf         (mf),
    .start      (start),
    .car        (car),
    .halted     (halted),
    .instr_done (instr_done),
    .retired    (retired),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_car;
  bit m_halted;
  bit m_done;
  bit m_err;
  int m_ret;
  int exmap [256];
  int dones;

  task automatic chk(string tag, logic [15:0] obs,
                     logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // test microprogram: {halt_bit, car_ctrl} per address
  function automatic logic [2:0] ucode(int a);
    if (a == 4 || a == 6) return 3'b001;
    if (a == 8'h14) return 3'b111;
    if (a <= 5) return 3'b010;
    if (a >= 7 && a <= 31) return (a % 2) ? 3'b010 : 3'b011;
    if (a == 32 || a == 36) return 3'b011;
    if (a >= 33 && a <= 35) return 3'b010;
    return 3'b000;
  endfunction

  function automatic void model_reset();
    m_car = 0; m_halted = 0; m_done = 0;
    m_err = 0; m_ret = 0;
  endfunction

  function automatic void model_step(logic [1:0] c,
                                     logic hb, logic st);
    int t;
    m_done = 0;
    if (m_halted) begin
      if (st && !hb) begin
        m_halted = 0;
        m_car = 0;
      end
      return;
    end
    if (c == 2'b10) begin
      if (m_car == 127) begin
        m_car = 0;
        m_err = 1;
      end else m_car = m_car + 1;
    end else if (c == 2'b01) begin
      if (m_car == 4 && ind) m_car = 5;
      else begin
        t = exmap[opcode];
        if (opcode == 8'h05) t = acc_gt0 ? 'h11 : 'h1F;
        if (t < 0) begin
          t = 'h1F;
          m_err = 1;
        end
        m_car = t;
      end
    end else if (c == 2'b11) begin
      if (m_car == 8 && mf) m_car = 'h21;
      else begin
        m_car = 0;
        m_done = 1;
        if (m_ret < 65535) m_ret = m_ret + 1;
      end
    end
    if (hb) m_halted = 1;
  endfunction

  task automatic step(logic [1:0] c, logic hb, logic st);
    car_ctrl = c;
    halt_bit = hb;
    start = st;
    @(posedge clk);
    #1;
    model_step(c, hb, st);
    if (m_done) dones++;
    chk("car", 16'(car), 16'(m_car));
    chk("halted", 16'(halted), 16'(m_halted));
    chk("instr_done", 16'(instr_done), 16'(m_done));
    chk("retired", retired, 16'(m_ret));
    chk("err", 16'(err), 16'(m_err));
  endtask

  task automatic ustep();
    logic [2:0] u;
    u = ucode(m_car);
    step(u[1:0], u[2], 1'b0);
  endtask

  task automatic run_expect(string tag, int exp[$]);
    foreach (exp[i]) begin
      ustep();
      chk(tag, 16'(car), 16'(exp[i]));
    end
  endtask

  initial begin
    int op_list[$];
    int k;
    int r0;
    logic [2:0] u;
    foreach (exmap[i]) exmap[i] = -1;
    exmap[1] = 'h07; exmap[2] = 'h09; exmap[3] = 'h0B;
    exmap[4] = 'h0D; exmap[5] = 'h11; exmap[6] = 'h11;
    exmap[7] = 'h13; exmap[8] = 'h0F; exmap[10] = 'h15;
    exmap[11] = 'h17; exmap[12] = 'h19; exmap[13] = 'h1B;
    exmap[14] = 'h1D;
    dones = 0;
    rst = 1; halt_bit = 0; car_ctrl = 0; opcode = 0;
    ind = 0; acc_gt0 = 0; mf = 0; start = 0;
    model_reset();
    #2;
    chk("rst_car", 16'(car), 16'h0);
    chk("rst_halted", 16'(halted), 16'h0);
    chk("rst_retired", retired, 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    #10 rst = 0;

    // ADD direct
    opcode = 8'h03; ind = 0;
    dones = 0;
    run_expect("add", '{1, 2, 3, 4, 'h0B, 'h0C, 0});
    chk("add_done_cnt", 16'(dones), 16'd1);
    chk("add_retired", retired, 16'd1);

    // LOAD indirect
    opcode = 8'h02; ind = 1;
    run_expect("load_ind", '{1, 2, 3, 4, 5, 6, 'h09, 'h0A, 0});
    ind = 0;

    // JGZ both ways
    opcode = 8'h05; acc_gt0 = 0;
    run_expect("jgz0", '{1, 2, 3, 4, 'h1F, 'h20, 0});
    acc_gt0 = 1;
    run_expect("jgz1", '{1, 2, 3, 4, 'h11, 'h12, 0});
    acc_gt0 = 0;

    // STORE with multiply-high
    opcode = 8'h01; mf = 1;
    r0 = retired;
    run_expect("storeh",
      '{1, 2, 3, 4, 7, 8, 'h21, 'h22, 'h23, 'h24, 0});
    chk("storeh_ret", retired, 16'(r0 + 1));
    mf = 0;

    // HALT, ignored inputs, start/halt priority, resume
    opcode = 8'h07;
    run_expect("halt", '{1, 2, 3, 4, 'h13, 'h14, 0});
    chk("halt_flag", 16'(halted), 16'd1);
    for (int i = 0; i < 10; i++) begin
      opcode = 8'($urandom);
      step(2'($urandom), 1'($urandom), 1'b0);
      chk("halt_hold", 16'(car), 16'h0);
    end
    step(2'b10, 1'b1, 1'b1);
    chk("halt_prio", 16'(halted), 16'd1);
    step(2'b10, 1'b0, 1'b1);
    chk("resume_h", 16'(halted), 16'd0);
    chk("resume_car", 16'(car), 16'h0);
    ustep();
    chk("resume_fetch", 16'(car), 16'h01);
    run_expect("resume_rest", '{2, 3});

    // finish that fetch with an illegal opcode
    opcode = 8'hFF;
    run_expect("illegal", '{4, 'h1F});
    chk("illegal_err", 16'(err), 16'd1);
    run_expect("illegal_end", '{'h20, 0});

    // reset mid-routine, no clock edge
    opcode = 8'h03;
    run_expect("add2", '{1, 2, 3, 4, 'h0B});
    #1 rst = 1;
    #1;
    chk("arst_car", 16'(car), 16'h0);
    chk("arst_err", 16'(err), 16'h0);
    chk("arst_halted", 16'(halted), 16'h0);
    chk("arst_done", 16'(instr_done), 16'h0);
    chk("arst_retired", retired, 16'h0);
    #1 rst = 0;
    model_reset();
    ustep();
    chk("post_rst", 16'(car), 16'h01);
    run_expect("post_rst_rest", '{2, 3, 4, 'h0B, 'h0C, 0});

    // increment wrap at 0x7F
    for (int i = 0; i < 127; i++) step(2'b10, 1'b0, 1'b0);
    chk("wrap_pre", 16'(car), 16'h7F);
    chk("wrap_pre_err", 16'(err), 16'd0);
    step(2'b10, 1'b0, 1'b0);
    chk("wrap_car", 16'(car), 16'h0);
    chk("wrap_err", 16'(err), 16'd1);

    // random instruction stream
    op_list = '{1, 2, 3, 4, 5, 6, 7, 8, 10, 11, 12, 13,
                14, 'hFF, 9, 0};
    for (int n = 0; n < 300; n++) begin
      if (m_halted) begin
        k = $urandom_range(2, 5);
        for (int i = 0; i < k; i++)
          step(2'($urandom), 1'($urandom), 1'b0);
        step(2'b00, 1'b0, 1'b1);
      end
      opcode = 8'(op_list[$urandom_range(0, 15)]);
      if (($urandom % 8) == 0) opcode = 8'($urandom);
      ind = 1'($urandom);
      k = 0;
      do begin
        acc_gt0 = 1'($urandom);
        mf = 1'($urandom);
        u = ucode(m_car);
        step(u[1:0], u[2], ($urandom % 8) == 0);
        k++;
      end while (m_car != 0 && k < 40);
      if (m_car != 0) chk("bound", 16'(car), 16'h0);
    end

    // retired saturation
    if (m_halted) step(2'b00, 1'b0, 1'b1);
    k = 0;
    while (m_ret < 65535 && k < 70000) begin
      step(2'b11, 1'b0, 1'b0);
      k++;
    end
    chk("sat_reach", retired, 16'hFFFF);
    step(2'b11, 1'b0, 1'b0);
    chk("sat_hold", retired, 16'hFFFF);
    chk("sat_done", 16'(instr_done), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/car_sequencer.md
CAR_SEQUENCER -- requirements
Module: car_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port halt_bit, input, 1, control_word[23], the global halt request.
REQ-004 SHALL have port car_ctrl, input, 2, control_word[21:20]: 00 hold, 01 dispatch, 10 increment, 11 return.
REQ-005 SHALL have port opcode, input, 8, the IR opcode field, stable from ID2 onward.
REQ-006 SHALL have port ind, input, 1, the IR indirect-addressing bit.
REQ-007 SHALL have port acc_gt0, input, 1, ACC > 0 flag, used by JGZ.
REQ-008 SHALL have port mf, input, 1, multiply-result-high flag.
REQ-009 SHALL have port start, input, 1, single-cycle resume pulse.
REQ-010 SHALL have port car, output, 7, the registered control address to the control memory.
REQ-011 SHALL have port halted, output, 1, registered run/halt status.
REQ-012 SHALL have port instr_done, output, 1, one-cycle pulse when an instruction completes.
REQ-013 SHALL have port retired, output, 16, a saturating count of completed instructions.
REQ-014 SHALL have port err, output, 1, a sticky flag for illegal opcode or CAR overflow.

Function
REQ-015 SHALL register car; the control word for a car value is combinational, so next_car takes effect on the following edge with 1-cycle latency.
REQ-016 SHALL, for car_ctrl=00, keep car unchanged.
REQ-017 SHALL, for car_ctrl=10, set car to car+1; increment from 0x7F SHALL wrap to 0x00 and set err.
REQ-018 SHALL, for car_ctrl=01 at car=0x04 with ind=1, set car to 0x05 (IND1); otherwise dispatch by opcode.
REQ-019 SHALL use this opcode->car dispatch map: 01 STORE->07, 02 LOAD->09, 03 ADD->0B, 04 SUB->0D, 05 JGZ->11 if acc_gt0 else 1F, 06 JMP->11, 07 HALT->13, 08 MPY->0F, 0A AND->15, 0B OR->17, 0C NOT->19, 0D SHIFTR->1B, 0E SHIFTL->1D.
REQ-020 SHALL dispatch any unmapped opcode to 0x1F (NOP) and set err.
REQ-021 SHALL, for car_ctrl=11 at car=0x08 with mf=1, set car to 0x21 (STOREH); otherwise set car to 0x00.
REQ-022 SHALL pulse instr_done and increment retired (saturating at 0xFFFF) on each car_ctrl=11 transition that targets 0x00.
REQ-023 SHALL, when halt_bit=1 while running, apply the normal car_ctrl transition, set halted=1 next cycle and freeze car.
REQ-024 SHALL ignore halt_bit, car_ctrl and opcode while halted=1, except for start.
REQ-025 SHALL, on start=1 while halted, clear halted next cycle and resume from car=0x00.
REQ-026 SHALL ignore start while running.
REQ-027 SHALL let halt take priority over start when both are asserted in the same cycle.
REQ-028 SHALL sample acc_gt0, mf and ind only in the cycle the decision is made.

Reset
REQ-029 SHALL, on rst assertion at any time including mid-microroutine, immediately force car=0x00, halted=0, instr_done=0, retired=0, err=0.
REQ-030 SHALL fetch from 0x00 on the first clk edge after rst deasserts.

Structure
REQ-031 SHALL take opcodes, car_ctrl encodings (HOLD/DISP/INC/RET) and microroutine base addresses (IF, FO, IND1, NOP, STOREH, each EX entry) from shared package cu_pkg, which is also used by the control memory.
REQ-032 SHALL implement the opcode/flag dispatch as the combinational sub-module car_dispatch, with inputs opcode and acc_gt0 and outputs target and illegal.

Verification
REQ-033 SHALL cover ADD, direct: opcode 03, ind=0 -> car 00,01,02,03,04,0B,0C,00; instr_done pulses once; retired=1.
REQ-034 SHALL cover LOAD, indirect: opcode 02, ind=1 -> car 04,05,06,09,0A,00.
REQ-035 SHALL cover JGZ: opcode 05 with acc_gt0=0 -> 04 then 1F,20,00; with acc_gt0=1 -> 04 then 11,12,00.
REQ-036 SHALL cover STORE with MPY high: opcode 01, mf=1 -> 07,08,21,22,23,24,00; retired increments exactly once.
REQ-037 SHALL cover HALT: opcode 07 -> 13,14,00, halted=1, car held at 00 for 10 cycles; start pulse -> halted=0, car 00->01.
REQ-038 SHALL cover illegal opcode and reset: opcode FF -> car 1F, err=1; rst asserted at car=0x0B -> car=00, err=0 with no clk edge.
